// File: rtl/sram_pkg.sv
// Shared SRAM front-end definitions: FSM encoding,
// controller idle code and default bus widths.
package sram_pkg;

  localparam int SRAM_AW = 4;
  localparam int SRAM_DW = 4;

  localparam logic [1:0] CTL_IDLE = 2'd0;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } q_state_t;

endpackage

// File: rtl/sram_cmd_fifo.sv
// Command FIFO: DEPTH entries of W bits,
// head visible on dout while non-empty.
module sram_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 9
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // A full FIFO refuses a push even when a pop frees a slot
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)
        count <= count + 1'b1;
      else if (do_pop && !do_push)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/sram_req_queue.sv
// Host request queue in front of the SRAM controller:
// issues one command at a time, returns read data.
module sram_req_queue
  import sram_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = SRAM_AW,
  parameter int DW    = SRAM_DW,
  parameter int TMO   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [AW-1:0] rsp_addr,
  output logic [DW-1:0] rsp_rdata,
  output logic          ctl_write,
  output logic          ctl_read,
  output logic [AW-1:0] ctl_addr,
  output logic [DW-1:0] ctl_wdata,
  input  logic [DW-1:0] ctl_rdata,
  input  logic [1:0]    ctl_state,
  output logic          busy,
  output logic          err_tmo
);

  localparam int W  = 1 + AW + DW;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TMO + 1);

  q_state_t      state;
  q_state_t      state_nxt;
  logic [W-1:0]  head;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          pop;
  logic          rsp_set;
  logic          tmo_fire;
  logic          cmd_we;
  logic [TW-1:0] tmo_cnt;
  logic          h_we;
  logic [AW-1:0] h_addr;
  logic [DW-1:0] h_wdata;

  assign req_ready = !full;
  assign busy      = (count != '0) || (state != ST_IDLE);
  assign {h_we, h_addr, h_wdata} = head;

  sram_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (req_valid && req_ready),
    .pop   (pop),
    .din   ({req_we, req_addr, req_wdata}),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    rsp_set   = 1'b0;
    tmo_fire  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!empty && ctl_state == CTL_IDLE) begin
          pop       = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: state_nxt = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (ctl_state != CTL_IDLE) begin
          state_nxt = ST_WAIT_DONE;
        end else if (tmo_cnt == TW'(TMO - 1)) begin
          tmo_fire  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_WAIT_DONE: begin
        if (ctl_state == CTL_IDLE) begin
          rsp_set   = !cmd_we;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Strobes are loaded on the pop edge so they are high exactly in ISSUE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctl_write <= 1'b0;
      ctl_read  <= 1'b0;
      ctl_addr  <= '0;
      ctl_wdata <= '0;
      cmd_we    <= 1'b0;
    end else begin
      ctl_write <= pop && h_we;
      ctl_read  <= pop && !h_we;
      if (pop) begin
        ctl_addr  <= h_addr;
        ctl_wdata <= h_wdata;
        cmd_we    <= h_we;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid <= 1'b0;
      rsp_addr  <= '0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= rsp_set;
      if (rsp_set) begin
        rsp_addr  <= ctl_addr;
        rsp_rdata <= ctl_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt <= '0;
      err_tmo <= 1'b0;
    end else begin
      if (state == ST_WAIT_BUSY) tmo_cnt <= tmo_cnt + 1'b1;
      else                       tmo_cnt <= '0;
      if (tmo_fire) err_tmo <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_req_queue.sv
// Directed bench for sram_req_queue with a small
// behavioural SRAM controller model.
module tb_sram_req_queue;

  localparam int TMO = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [3:0] req_addr;
  logic [3:0] req_wdata;
  logic       rsp_valid;
  logic [3:0] rsp_addr;
  logic [3:0] rsp_rdata;
  logic       ctl_write;
  logic       ctl_read;
  logic [3:0] ctl_addr;
  logic [3:0] ctl_wdata;
  logic [3:0] ctl_rdata;
  logic [1:0] ctl_state;
  logic       busy;
  logic       err_tmo;

  int n_tests = 0;
  int n_fail  = 0;

  logic ctl_hold;
  logic ctl_dead;
  int   busy_len;

  logic [3:0] wa_q[$];
  logic [3:0] wd_q[$];
  logic [3:0] ra_q[$];
  logic [3:0] pa_q[$];
  logic [3:0] pd_q[$];
  int   n_wide  = 0;
  int   n_early = 0;
  logic prev_strobe = 1'b0;
  logic [1:0] prev_state = 2'd0;

  sram_req_queue #(
    .DEPTH (4),
    .AW    (4),
    .DW    (4),
    .TMO   (TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_addr  (rsp_addr),
    .rsp_rdata (rsp_rdata),
    .ctl_write (ctl_write),
    .ctl_read  (ctl_read),
    .ctl_addr  (ctl_addr),
    .ctl_wdata (ctl_wdata),
    .ctl_rdata (ctl_rdata),
    .ctl_state (ctl_state),
    .busy      (busy),
    .err_tmo   (err_tmo)
  );

  always #5 clk = ~clk;

  // Controller model: busy for busy_len cycles after each strobe
  initial begin
    logic [3:0] mem [16];
    int busy_left;
    for (int i = 0; i < 16; i++) mem[i] = 4'd0;
    busy_left = 0;
    ctl_state = 2'd0;
    ctl_rdata = 4'd0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        busy_left = 0;
      end else if (!ctl_dead && (ctl_write || ctl_read)) begin
        if (ctl_write) mem[ctl_addr] = ctl_wdata;
        else           ctl_rdata = mem[ctl_addr];
        busy_left = busy_len;
      end else if (busy_left > 0) begin
        busy_left--;
      end
      ctl_state = (busy_left > 0 || ctl_hold) ? 2'd1 : 2'd0;
    end
  end

  always @(negedge clk) begin
    if (ctl_write || ctl_read) begin
      if (prev_strobe) n_wide++;
      if (prev_state != 2'd0) n_early++;
      if (ctl_write) begin
        wa_q.push_back(ctl_addr);
        wd_q.push_back(ctl_wdata);
      end else begin
        ra_q.push_back(ctl_addr);
      end
    end
    if (rsp_valid) begin
      pa_q.push_back(rsp_addr);
      pd_q.push_back(rsp_rdata);
    end
    prev_strobe = ctl_write || ctl_read;
    prev_state  = ctl_state;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic we, input logic [3:0] a,
                      input logic [3:0] d);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("push_ready", req_ready, 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((busy || ctl_state != 2'd0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, busy, 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int n;
    rst       = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 4'd0;
    req_wdata = 4'd0;
    ctl_hold  = 1'b0;
    ctl_dead  = 1'b0;
    busy_len  = 2;

    #12;
    chk("rst_write", ctl_write, 0);
    chk("rst_read", ctl_read, 0);
    chk("rst_rsp", rsp_valid, 0);
    chk("rst_err", err_tmo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 1);
    chk("rst_addr", ctl_addr, 0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 1; i <= 4; i++) push(1'b1, 4'(i), 4'(i));
    wait_idle("wr_idle");
    chk("wr_count", wa_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("wr_addr%0d", i), wa_q[i], i + 1);
      chk($sformatf("wr_data%0d", i), wd_q[i], i + 1);
    end

    for (int i = 1; i <= 4; i++) push(1'b0, 4'(i), 4'd0);
    wait_idle("rd_idle");
    chk("rd_strobes", ra_q.size(), 4);
    chk("rsp_count", pa_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rsp_addr%0d", i), pa_q[i], i + 1);
      chk($sformatf("rsp_data%0d", i), pd_q[i], i + 1);
    end

    wa_q.delete();
    wd_q.delete();
    @(negedge clk);
    ctl_hold = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) push(1'b1, 4'(5 + i), 4'(9 + i));
    chk("full_ready", req_ready, 0);
    chk("full_busy", busy, 1);
    chk("held_no_strobe", wa_q.size(), 0);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 4'd9;
    req_wdata = 4'd13;
    chk("fifth_blocked", req_ready, 0);
    ctl_hold = 1'b0;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("full_pop_delay", n, 2);
    chk("full_pop_strobe", ctl_write, 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_idle("full_idle");
    chk("full_count", wa_q.size(), 5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("full_addr%0d", i), wa_q[i], 5 + i);
      chk($sformatf("full_data%0d", i), wd_q[i], 9 + i);
    end

    pa_q.delete();
    pd_q.delete();
    ctl_dead = 1'b1;
    chk("tmo_pre", err_tmo, 0);
    push(1'b0, 4'd3, 4'd0);
    n = 0;
    while (!ctl_read && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_strobe", ctl_read, 1);
    n = 0;
    while (!err_tmo && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_latency", n, TMO + 1);
    chk("tmo_idle", busy, 0);
    ctl_dead = 1'b0;
    push(1'b0, 4'd2, 4'd0);
    wait_idle("tmo_next_idle");
    chk("tmo_rsp_count", pa_q.size(), 1);
    chk("tmo_rsp_addr", pa_q[0], 2);
    chk("tmo_rsp_data", pd_q[0], 2);
    chk("tmo_sticky", err_tmo, 1);

    busy_len = 6;
    push(1'b0, 4'd1, 4'd0);
    push(1'b0, 4'd2, 4'd0);
    push(1'b0, 4'd3, 4'd0);
    repeat (2) @(negedge clk);
    chk("wd_addr", ctl_addr, 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_addr", ctl_addr, 0);
    chk("arst_wdata", ctl_wdata, 0);
    chk("arst_read", ctl_read, 0);
    chk("arst_write", ctl_write, 0);
    chk("arst_rsp_addr", rsp_addr, 0);
    chk("arst_rsp_data", rsp_rdata, 0);
    chk("arst_rsp", rsp_valid, 0);
    chk("arst_err", err_tmo, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ready", req_ready, 1);
    wa_q.delete();
    ra_q.delete();
    pa_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    chk("post_rst_reads", ra_q.size(), 0);
    chk("post_rst_writes", wa_q.size(), 0);
    chk("post_rst_rsp", pa_q.size(), 0);
    chk("post_rst_busy", busy, 0);

    chk("strobe_width", n_wide, 0);
    chk("issue_after_idle", n_early, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
